// File: rtl/regfile_pkg.sv
// Shared definitions for the i281 parametrised register file: clear-engine
// states, default sizing and the architectural register indices.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
    localparam int REG_D = 3;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_e;

    function automatic logic sel_ok(input int sel, input int num_regs);
        return sel < num_regs;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: one write port, a load-lock request, two read
// ports with lock status, and the clear-sweep handshake.
interface regfile_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
);
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0]  rd0_sel;
    logic [SEL_W-1:0]  rd1_sel;
    logic [DATA_W-1:0] rd0_data;
    logic [DATA_W-1:0] rd1_data;
    logic              rd0_locked;
    logic              rd1_locked;
    logic              lock_en;
    logic [SEL_W-1:0]  lock_sel;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output wr_en, wr_sel, wr_data, rd0_sel, rd1_sel, lock_en, lock_sel, clr_req,
        input  rd0_data, rd1_data, rd0_locked, rd1_locked, clr_busy, clr_done
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd0_sel, rd1_sel, lock_en, lock_sel, clr_req,
        output rd0_data, rd1_data, rd0_locked, rd1_locked, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks idx across every register, one per cycle,
// then pulses clr_done for a single cycle. All outputs are registered.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr_req,
    output logic             o_clr_busy,
    output logic             o_clr_done,
    output logic             o_clr_we,
    output logic [SEL_W-1:0] o_clr_idx
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    clr_state_e       r_state;
    logic [SEL_W-1:0] r_idx;
    logic             r_busy;
    logic             r_done;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLR_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLR_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLR_SWEEP;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= CLR_DONE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                CLR_DONE: r_state <= CLR_IDLE;
                default:  r_state <= CLR_IDLE;
            endcase
        end
    end

    assign o_clr_busy = r_busy;
    assign o_clr_done = r_done;
    assign o_clr_we   = r_busy;
    assign o_clr_idx  = r_idx;

endmodule

// File: rtl/regfile_param.sv
// Parametrised i281 register file: storage, per-register load locks,
// write/lock arbitration against the clear engine, and two read muxes.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;

    logic              w_clr_busy;
    logic              w_clr_done;
    logic              w_clr_we;
    logic [SEL_W-1:0]  w_clr_idx;
    logic              w_ext_ok;
    logic              w_wr_acc;
    logic              w_lock_acc;
    logic [DATA_W-1:0] w_rd0_data;
    logic [DATA_W-1:0] w_rd1_data;
    logic              w_rd0_locked;
    logic              w_rd1_locked;

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_clr_req  (bus.clr_req),
        .o_clr_busy (w_clr_busy),
        .o_clr_done (w_clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_idx  (w_clr_idx)
    );

    // External traffic is dropped for the whole sweep, including the done cycle.
    assign w_ext_ok   = !w_clr_busy && !w_clr_done && !reset;
    assign w_wr_acc   = bus.wr_en && w_ext_ok && sel_ok(int'(bus.wr_sel), NUM_REGS);
    assign w_lock_acc = bus.lock_en && w_ext_ok && sel_ok(int'(bus.lock_sel), NUM_REGS);

    // NOTE: the storage array is reset explicitly because software relies on a
    // zeroed file after reset; that forbids mapping it onto RAM macros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_lock <= '0;
        end else begin
            if (w_clr_we) begin
                r_regs[w_clr_idx] <= '0;
                r_lock[w_clr_idx] <= 1'b0;
            end
            if (w_wr_acc) begin
                r_regs[bus.wr_sel] <= bus.wr_data;
                r_lock[bus.wr_sel] <= 1'b0;
            end
            // Placed last so a lock on the register being written wins.
            if (w_lock_acc) begin
                r_lock[bus.lock_sel] <= 1'b1;
            end
        end
    end

    // NOTE: every output of the combinational muxes gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rd0_data   = '0;
        w_rd0_locked = 1'b0;
        if (sel_ok(int'(bus.rd0_sel), NUM_REGS)) begin
            w_rd0_data   = r_regs[bus.rd0_sel];
            w_rd0_locked = r_lock[bus.rd0_sel];
        end
        if (BYPASS != 0 && w_wr_acc && bus.rd0_sel == bus.wr_sel) begin
            w_rd0_data   = bus.wr_data;
            w_rd0_locked = 1'b0;
        end
    end

    always_comb begin
        w_rd1_data   = '0;
        w_rd1_locked = 1'b0;
        if (sel_ok(int'(bus.rd1_sel), NUM_REGS)) begin
            w_rd1_data   = r_regs[bus.rd1_sel];
            w_rd1_locked = r_lock[bus.rd1_sel];
        end
        if (BYPASS != 0 && w_wr_acc && bus.rd1_sel == bus.wr_sel) begin
            w_rd1_data   = bus.wr_data;
            w_rd1_locked = 1'b0;
        end
    end

    assign bus.rd0_data   = w_rd0_data;
    assign bus.rd1_data   = w_rd1_data;
    assign bus.rd0_locked = w_rd0_locked;
    assign bus.rd1_locked = w_rd1_locked;
    assign bus.clr_busy   = w_clr_busy;
    assign bus.clr_done   = w_clr_done;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboarded bench for regfile_param: two configurations (8x4 with bypass,
// 16x6 without) share one stimulus stream and one reference model.
module tb_regfile_param;
    import regfile_pkg::*;

    localparam int NI = 2;
    localparam int NREGS [NI] = '{4, 6};
    localparam int SELW  [NI] = '{2, 3};
    localparam int DW    [NI] = '{8, 16};
    localparam int BYP   [NI] = '{1, 0};

    typedef struct {
        bit wr_en;
        int wr_sel;
        int wr_data;
        bit lock_en;
        int lock_sel;
        int rd0;
        int rd1;
        bit clr_req;
        bit rst;
    } stim_t;

    typedef struct {
        int inst;
        int cyc;
        int d0;
        int d1;
        bit l0;
        bit l1;
        bit busy;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    regfile_if #(.DATA_W(8),  .SEL_W(2)) bus0 ();
    regfile_if #(.DATA_W(16), .SEL_W(3)) bus1 ();

    regfile_param #(.DATA_W(8), .NUM_REGS(4), .BYPASS(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    regfile_param #(.DATA_W(16), .NUM_REGS(6), .BYPASS(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Reference model: register contents, locks, and the sweep start edge.
    int m_reg  [NI][16];
    bit m_lock [NI][16];
    bit m_act  [NI];
    int m_k    [NI];
    int edge_n = 0;
    bit m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_read(input int i, input int sel, input bit wacc,
                                       input int ws, input int wd,
                                       output int d, output bit l);
        d = 0;
        l = 1'b0;
        if (sel < NREGS[i]) begin
            d = m_reg[i][sel];
            l = m_lock[i][sel];
        end
        if (BYP[i] != 0 && wacc && sel == ws) begin
            d = wd;
            l = 1'b0;
        end
    endfunction

    task automatic model_cycle(input int i, input stim_t s);
        int   n     = NREGS[i];
        int   smask = (1 << SELW[i]) - 1;
        int   dmask = (1 << DW[i]) - 1;
        int   ws    = s.wr_sel & smask;
        int   wd    = s.wr_data & dmask;
        int   ls    = s.lock_sel & smask;
        bit   was_act = m_act[i];
        bit   busy  = m_act[i] && edge_n >= m_k[i] + 1 && edge_n <= m_k[i] + n;
        bit   done  = m_act[i] && edge_n == m_k[i] + n + 1;
        bit   ok    = !busy && !done && !s.rst;
        bit   wacc  = s.wr_en && ok && ws < n;
        bit   lacc  = s.lock_en && ok && ls < n;
        exp_t x;
        x.inst = i;
        x.cyc  = edge_n;
        x.busy = busy;
        x.done = done;
        model_read(i, s.rd0 & smask, wacc, ws, wd, x.d0, x.l0);
        model_read(i, s.rd1 & smask, wacc, ws, wd, x.d1, x.l1);
        if (m_valid) exp_q.push_back(x);
        if (s.rst) begin
            for (int r = 0; r < 16; r++) begin
                m_reg[i][r]  = 0;
                m_lock[i][r] = 1'b0;
            end
            m_act[i] = 1'b0;
        end else begin
            if (busy) begin
                m_reg[i][edge_n - m_k[i] - 1]  = 0;
                m_lock[i][edge_n - m_k[i] - 1] = 1'b0;
            end
            if (wacc) begin
                m_reg[i][ws]  = wd;
                m_lock[i][ws] = 1'b0;
            end
            if (lacc) m_lock[i][ls] = 1'b1;
            if (done) m_act[i] = 1'b0;
            if (!was_act && s.clr_req) begin
                m_act[i] = 1'b1;
                m_k[i]   = edge_n;
            end
        end
    endtask

    function automatic stim_t idle(input int r0, input int r1);
        stim_t s;
        s.wr_en = 1'b0; s.wr_sel = 0; s.wr_data = 0;
        s.lock_en = 1'b0; s.lock_sel = 0;
        s.rd0 = r0; s.rd1 = r1;
        s.clr_req = 1'b0; s.rst = 1'b0;
        return s;
    endfunction

    function automatic stim_t wr(input int sel, input int data, input int r0, input int r1);
        stim_t s = idle(r0, r1);
        s.wr_en = 1'b1; s.wr_sel = sel; s.wr_data = data;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reset         = s.rst;
        bus0.wr_en    = s.wr_en;   bus1.wr_en    = s.wr_en;
        bus0.wr_sel   = 2'(s.wr_sel);   bus1.wr_sel   = 3'(s.wr_sel);
        bus0.wr_data  = 8'(s.wr_data);  bus1.wr_data  = 16'(s.wr_data);
        bus0.lock_en  = s.lock_en; bus1.lock_en  = s.lock_en;
        bus0.lock_sel = 2'(s.lock_sel); bus1.lock_sel = 3'(s.lock_sel);
        bus0.rd0_sel  = 2'(s.rd0);  bus1.rd0_sel  = 3'(s.rd0);
        bus0.rd1_sel  = 2'(s.rd1);  bus1.rd1_sel  = 3'(s.rd1);
        bus0.clr_req  = s.clr_req; bus1.clr_req  = s.clr_req;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        for (int i = 0; i < NI; i++) model_cycle(i, s);
        edge_n++;
        if (s.rst) m_valid = 1'b1;
    endtask

    task automatic fill_all();
        for (int r = 0; r < 6; r++) step(wr(r, 16'hA0A1 + r, r, 5 - r));
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) step(idle(r, 7 - r));
    endtask

    // Monitor: read ports are always presenting data, so compare every cycle.
    always @(negedge clk) begin : monitor
        exp_t        x;
        logic [31:0] a_d0, a_d1, a_l0, a_l1, a_busy, a_done;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            if (x.inst == 0) begin
                a_d0 = 32'(bus0.rd0_data);    a_d1 = 32'(bus0.rd1_data);
                a_l0 = 32'(bus0.rd0_locked);  a_l1 = 32'(bus0.rd1_locked);
                a_busy = 32'(bus0.clr_busy);  a_done = 32'(bus0.clr_done);
            end else begin
                a_d0 = 32'(bus1.rd0_data);    a_d1 = 32'(bus1.rd1_data);
                a_l0 = 32'(bus1.rd0_locked);  a_l1 = 32'(bus1.rd1_locked);
                a_busy = 32'(bus1.clr_busy);  a_done = 32'(bus1.clr_done);
            end
            check($sformatf("u%0d cyc%0d rd0_data", x.inst, x.cyc), a_d0, 32'(x.d0));
            check($sformatf("u%0d cyc%0d rd1_data", x.inst, x.cyc), a_d1, 32'(x.d1));
            check($sformatf("u%0d cyc%0d rd0_locked", x.inst, x.cyc), a_l0, 32'(x.l0));
            check($sformatf("u%0d cyc%0d rd1_locked", x.inst, x.cyc), a_l1, 32'(x.l1));
            check($sformatf("u%0d cyc%0d clr_busy", x.inst, x.cyc), a_busy, 32'(x.busy));
            check($sformatf("u%0d cyc%0d clr_done", x.inst, x.cyc), a_done, 32'(x.done));
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
        end
        s = idle(0, 0);
        s.rst = 1'b1;
        drive(s);

        step(s);
        step(s);
        step(idle(REG_A, REG_D));

        // Basic write then read-back on the next cycle.
        step(wr(REG_A, 8'h5A, REG_A, REG_D));
        step(wr(REG_D, 8'hC3, REG_A, REG_D));
        step(idle(REG_A, REG_D));

        // Same-cycle forwarding (only the bypass instance forwards).
        step(wr(REG_B, 8'h77, REG_B, REG_A));
        step(idle(REG_B, REG_A));

        // Lock scoreboard: lock, clear by write, then lock beats write.
        s = idle(REG_A, REG_C);
        s.lock_en = 1'b1; s.lock_sel = REG_C;
        step(s);
        step(idle(REG_A, REG_C));
        step(wr(REG_C, 8'h11, REG_A, REG_C));
        step(idle(REG_A, REG_C));
        s = wr(REG_C, 8'h22, REG_C, REG_C);
        s.lock_en = 1'b1; s.lock_sel = REG_C;
        step(s);
        step(idle(REG_A, REG_C));

        // Clear sweep with a dropped write at k+2 and an ignored request at k+3.
        fill_all();
        s = idle(0, 1); s.clr_req = 1'b1;
        step(s);
        step(idle(0, 1));
        s = wr(0, 16'h00FF, 0, 1); s.lock_en = 1'b1; s.lock_sel = 1;
        step(s);
        s = idle(0, 1); s.clr_req = 1'b1;
        step(s);
        read_all();
        read_all();

        // Reset in the middle of a sweep.
        fill_all();
        s = idle(2, 3); s.clr_req = 1'b1;
        step(s);
        step(idle(2, 3));
        s = idle(2, 3); s.rst = 1'b1;
        step(s);
        read_all();

        // Top register of the wide instance and out-of-range select 7.
        fill_all();
        step(wr(5, 16'hBEEF, 5, 7));
        step(idle(5, 7));
        step(wr(7, 16'h1234, 7, 5));
        read_all();

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            s.wr_en    = ($urandom_range(0, 1) == 1);
            s.wr_sel   = $urandom_range(0, 7);
            s.wr_data  = int'($urandom_range(0, 16'hFFFF));
            s.lock_en  = ($urandom_range(0, 3) == 0);
            s.lock_sel = $urandom_range(0, 7);
            s.rd0      = $urandom_range(0, 7);
            s.rd1      = (n % 3 == 0) ? s.wr_sel : $urandom_range(0, 7);
            s.clr_req  = ($urandom_range(0, 29) == 0);
            s.rst      = ($urandom_range(0, 149) == 0);
            step(s);
        end
        step(idle(0, 1));

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-register file for the i281 datapath; the next generation of the 4×8 register file between the writeback mux (C18) and the ALU inputs. It adds configurable width and depth, optional write-to-read bypass, a per-register load scoreboard, and a sequential clear engine that zeroes the file one register per cycle without a global reset.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 4, number of registers, 2..16
- SEL_W, $clog2(NUM_REGS), select width (derived)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write enable (C10)
- wr_sel  in  SEL_W  write select (C8C9)
- wr_data  in  DATA_W  write data
- rd0_sel / rd1_sel  in  SEL_W  read selects, port 0 (C4C5) / port 1 (C6C7)
- rd0_data / rd1_data  out  DATA_W  read data, port 0 (ALU A) / port 1 (C11 mux)
- rd0_locked / rd1_locked  out  1  selected register has a pending load
- lock_en  in  1  mark register lock_sel as pending-load
- lock_sel  in  SEL_W  register to lock
- clr_req  in  1  start clear sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes

## Operation
- Reads are combinational. Select ≥ NUM_REGS: data 0, locked 0.
- Write: on posedge with wr_en, not clr_busy, and wr_sel < NUM_REGS, reg[wr_sel] <= wr_data and lock[wr_sel] is cleared. Out-of-range write is ignored.
- Bypass (BYPASS=1): if wr_en, write accepted, and rd_sel == wr_sel, rd_data = wr_data and rd_locked = 0 in the same cycle. With BYPASS=0, the old value is returned.
- Lock: on posedge with lock_en and lock_sel in range, lock[lock_sel] <= 1.
  - If the same edge also writes the same register, lock wins (final lock=1, data written).
  - Lock requests are ignored while clr_busy.
- Clear FSM states:
  - IDLE → SWEEP on clr_req, idx <= 0.
  - SWEEP: each cycle reg[idx] <= 0 and lock[idx] <= 0, then idx++. After idx == NUM_REGS-1 → DONE.
  - DONE: clr_done = 1 for one cycle, then → IDLE.
- clr_req is ignored outside IDLE.
- During SWEEP and DONE, external writes and locks are dropped. No bypass occurs for a dropped write.
- Reset (any state, including mid-sweep): all registers 0, all locks 0, FSM to IDLE, idx 0.

## Timing
- Reset values: rd*_data 0 (no bypass active), rd*_locked 0, clr_busy 0, clr_done 0.
- Write latency:
  - Visible on rd*_data the cycle after the write edge.
  - With BYPASS=1, also visible in the write cycle.
- Lock latency: rd*_locked is high the cycle after the lock edge.
- Clear, with clr_req sampled at edge k:
  - clr_busy is high for cycles k+1 .. k+NUM_REGS.
  - reg i is zeroed at edge k+1+i.
  - clr_done is high for cycle k+NUM_REGS+1, and clr_busy is 0 in that cycle.
  - Total time from request to back in IDLE: NUM_REGS+2 cycles.
- The earliest new clr_req is accepted at edge k+NUM_REGS+2.

## Structure
- Shared package regfile_pkg:
  - clear FSM state enum (CLR_IDLE, CLR_SWEEP, CLR_DONE)
  - default width/depth constants
  - i281 register index constants REG_A..REG_D = 0..3
- Sub-module regfile_clear_fsm:
  - owns state and idx.
  - outputs clr_busy, clr_done, clr_we, clr_idx.
- Top level holds the storage array, lock vector, write/lock arbitration and read muxes.

## Test plan
- Write/read: write A=0x5A, D=0xC3, then read rd0_sel=0, rd1_sel=3 → 0x5A / 0xC3 next cycle. Before that, both read 0x00.
- Bypass: BYPASS=1, write B=0x77 with rd0_sel=1 in the same cycle → rd0_data=0x77 that cycle. BYPASS=0 → 0x00 that cycle, 0x77 next.
- Scoreboard: lock C → rd1_locked=1 next cycle. Write C=0x11 → locked 0, data 0x11. Simultaneous lock+write on C → locked 1, data written.
- Clear sweep, NUM_REGS=4, all regs nonzero:
  - clr_req at k → busy cycles k+1..k+4, done at k+5, all regs 0.
  - A write of 0xFF at k+2 is dropped.
  - A second clr_req at k+3 is ignored.
- Reset mid-sweep: reset at k+2 → busy 0 next cycle, all regs 0, clr_done never pulses.
- Generic sizing: DATA_W=16, NUM_REGS=6:
  - write reg 5=0xBEEF, read back 0xBEEF.
  - sel=7 read returns 0; sel=7 write changes nothing.
